// File: rtl/mult_8x8_seq_if.sv
// Handshake and data bundle for the sequential 8x8 multiplier.
interface mult_8x8_seq_if;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy;
   logic        done;
   logic [15:0] product;

   modport master (
      output start, a, b,
      input  busy, done, product
   );

   modport slave (
      input  start, a, b,
      output busy, done, product
   );
endinterface

// File: rtl/mult_8x8_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier sharing one
// 8-bit ripple-carry adder across eight iterations.
module mult_8x8_seq (
   input  logic           clk,
   input  logic           rst_n,
   mult_8x8_seq_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        w_load;
   logic [7:0]  r_acc;
   logic [7:0]  r_q;
   logic [7:0]  r_m;
   logic [2:0]  r_cnt;
   logic [15:0] r_prod;
   logic [7:0]  w_y;
   logic [7:0]  w_s;
   logic        w_co;

   always_comb begin : adder
      logic v_c;
      w_y  = r_q[0] ? r_m : 8'h00;
      w_s  = 8'h00;
      v_c  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         w_s[i] = r_acc[i] ^ w_y[i] ^ v_c;
         v_c    = (r_acc[i] & w_y[i]) |
                  (v_c & (r_acc[i] ^ w_y[i]));
      end
      w_co = v_c;
   end

   // The DONE exit edge also serves as an IDLE edge,
   // giving a 9-cycle minimum issue interval.
   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_next = S_RUN;
               w_load = 1'b1;
            end
         end
         S_RUN: begin
            if (r_cnt == 3'd7)
               w_next = S_DONE;
         end
         S_DONE: begin
            if (bus.start) begin
               w_next = S_RUN;
               w_load = 1'b1;
            end else begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_acc   <= 8'h00;
         r_q     <= 8'h00;
         r_m     <= 8'h00;
         r_cnt   <= 3'd0;
         r_prod  <= 16'h0000;
      end else begin
         r_state <= w_next;
         if (w_load) begin
            r_m   <= bus.a;
            r_q   <= bus.b;
            r_acc <= 8'h00;
            r_cnt <= 3'd0;
         end else if (r_state == S_RUN) begin
            r_acc <= {w_co, w_s[7:1]};
            r_q   <= {w_s[0], r_q[7:1]};
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd7)
               r_prod <= {w_co, w_s, r_q[7:1]};
         end
      end
   end

   assign bus.busy    = (r_state == S_RUN);
   assign bus.done    = (r_state == S_DONE);
   assign bus.product = r_prod;

endmodule

// File: tb/tb_mult_8x8_seq.sv
// Directed bench for mult_8x8_seq with a cycle-level reference model.
module tb_mult_8x8_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   mult_8x8_seq_if bus ();

   mult_8x8_seq u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Model: edges since the accepting edge (-1 = free).
   int          k = -1;
   logic [15:0] pend = 16'h0;
   logic [15:0] exp_prod = 16'h0;

   task automatic chk(input string nm,
                      input logic [15:0] act,
                      input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         k        = -1;
         exp_prod = 16'h0;
      end else begin
         if (k >= 0) k++;
         if (k == 9) k = -1;
         if (k == -1 && bus.start === 1'b1) begin
            k    = 0;
            pend = 16'(bus.a) * 16'(bus.b);
         end
         if (k == 8) exp_prod = pend;
      end
      #1;
      chk("busy", 16'(bus.busy), 16'(k >= 0 && k <= 7));
      chk("done", 16'(bus.done), 16'(k == 8));
      chk("product", bus.product, exp_prod);
      chk("busy_and_done", 16'(bus.busy & bus.done), 16'h0);
   end

   always @(negedge rst_n) begin
      k        = -1;
      exp_prod = 16'h0;
      #1;
      chk("rst_busy", 16'(bus.busy), 16'h0);
      chk("rst_done", 16'(bus.done), 16'h0);
      chk("rst_product", bus.product, 16'h0);
   end

   task automatic run_op(input logic [7:0] av,
                         input logic [7:0] bv,
                         input logic [15:0] lit,
                         input bit scramble,
                         input string nm);
      int nb;
      bit got;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = av;
      bus.b = bv;
      @(negedge clk);
      bus.start = 1'b0;
      nb  = 0;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         if (bus.busy) nb++;
         if (bus.done) begin
            got = 1;
         end else begin
            if (scramble) begin
               bus.a = 8'($urandom);
               bus.b = 8'($urandom);
            end
            @(negedge clk);
         end
      end
      chk({nm, "_done_seen"}, 16'(got), 16'h1);
      chk({nm, "_busy_cycles"}, 16'(nb), 16'd8);
      chk({nm, "_lit"}, bus.product, lit);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.a = 8'h00;
      bus.b = 8'h00;
      repeat (3) @(negedge clk);
      chk("init_product", bus.product, 16'h0000);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_busy", 16'(bus.busy), 16'h0);
      chk("idle_product", bus.product, 16'h0000);

      run_op(8'h0F, 8'h0F, 16'h00E1, 1'b0, "p0f");
      run_op(8'hFF, 8'hFF, 16'hFE01, 1'b0, "pff");
      run_op(8'h80, 8'h02, 16'h0100, 1'b0, "p80");
      run_op(8'h00, 8'hAB, 16'h0000, 1'b0, "p00");

      // Ignored starts during RUN and at the RUN->DONE edge.
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = 8'h12;
      bus.b = 8'h34;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      bus.start = 1'b1;
      bus.a = 8'hFF;
      bus.b = 8'hFF;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("ign_done", 16'(bus.done), 16'h1);
      chk("ign_product", bus.product, 16'h03A8);
      repeat (3) begin
         @(negedge clk);
         chk("ign_no_busy", 16'(bus.busy), 16'h0);
      end

      // Back-to-back with start held high.
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = 8'h03;
      bus.b = 8'h05;
      repeat (9) @(negedge clk);
      chk("b2b_done1", 16'(bus.done), 16'h1);
      chk("b2b_prod1", bus.product, 16'h000F);
      bus.a = 8'h10;
      bus.b = 8'h10;
      @(negedge clk);
      chk("b2b_busy2", 16'(bus.busy), 16'h1);
      repeat (8) @(negedge clk);
      chk("b2b_done2", 16'(bus.done), 16'h1);
      chk("b2b_prod2", bus.product, 16'h0100);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);

      // Reset in the middle of an operation.
      bus.start = 1'b1;
      bus.a = 8'hAA;
      bus.b = 8'h55;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #2;
      chk("mid_rst_busy", 16'(bus.busy), 16'h0);
      chk("mid_rst_product", bus.product, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_done", 16'(bus.done), 16'h0);
      run_op(8'h02, 8'h03, 16'h0006, 1'b0, "prst");

      // Operands change every cycle after acceptance.
      run_op(8'hC3, 8'h7D, 16'h5F37, 1'b1, "pscr");
      run_op(8'h12, 8'h34, 16'h03A8, 1'b1, "pscr2");

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
